// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: scans a register range through both read ports and streams (addr, data) beats with a running checksum
module regfile_dump_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] ReadReg1,
  output logic [ADDR_W-1:0] ReadReg2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t state;
  logic [ADDR_W:0] ptr, last;
  logic [ADDR_W-1:0] b_addr, p_lo;
  logic [DATA_W-1:0] b_data;
  logic b_valid, sel, ptr_last, xfer, bad_range;
  assign p_lo = ptr[ADDR_W-1:0];
  assign ptr_last = ptr == last;
  assign xfer = dump_valid && dump_ready;
  assign bad_range = first_reg > last_reg;
  // Slot 0 of each fetched pair goes straight to the output registers; slot 1 waits in b_addr/b_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      last <= '0;
      ReadReg1 <= '0;
      ReadReg2 <= '0;
      b_addr <= '0;
      b_data <= '0;
      b_valid <= 1'b0;
      sel <= 1'b0;
      dump_valid <= 1'b0;
      dump_addr <= '0;
      dump_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      checksum <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ptr <= {1'b0, first_reg};
          last <= {1'b0, last_reg};
          checksum <= '0;
          busy <= 1'b1;
          err <= bad_range;
          done <= bad_range;
          state <= bad_range ? DONE : FETCH;
          if (!bad_range) begin
            ReadReg1 <= first_reg;
            ReadReg2 <= first_reg == last_reg ? first_reg : first_reg + 1'b1;
          end
        end
        FETCH: if (abort) begin
          state <= IDLE;
          busy <= 1'b0;
        end else begin
          dump_valid <= 1'b1;
          dump_addr <= ReadReg1;
          dump_data <= ReadData1;
          b_addr <= ReadReg2;
          b_data <= ReadData2;
          b_valid <= !ptr_last;
          sel <= 1'b0;
          ptr <= ptr_last ? ptr + 1'b1 : ptr + 2'd2;
          state <= DRAIN;
        end
        DRAIN: if (abort) begin
          state <= IDLE;
          busy <= 1'b0;
          dump_valid <= 1'b0;
          b_valid <= 1'b0;
        end else if (xfer) begin
          checksum <= checksum + dump_data;
          if (!sel && b_valid) begin
            sel <= 1'b1;
            dump_addr <= b_addr;
            dump_data <= b_data;
          end else begin
            dump_valid <= 1'b0;
            b_valid <= 1'b0;
            if (ptr > last) begin
              state <= DONE;
              done <= 1'b1;
            end else begin
              state <= FETCH;
              ReadReg1 <= p_lo;
              ReadReg2 <= ptr_last ? p_lo : p_lo + 1'b1;
            end
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: randomized and directed checks of the dump reader against a range-walk reference model
module tb_regfile_dump_reader;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, dump_ready = 0;
  logic [4:0] first_reg = 0, last_reg = 0, rr1, rr2, dump_addr;
  logic [31:0] rd1, rd2, dump_data, checksum;
  logic dump_valid, busy, done, err;
  logic [31:0] regs [32];
  int n_checks = 0, n_fail = 0;
  int oa[$], ea[$];
  logic [31:0] od[$], ed[$], esum;
  int first_cyc, last_cyc, done_cyc, idle_cyc, stall_bad, timeout, abort_cyc;
  logic [4:0] f_rr1, f_rr2;
  logic err_at_done;

  always #5 clk = ~clk;
  assign rd1 = regs[rr1];
  assign rd2 = regs[rr2];

  regfile_dump_reader #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .first_reg(first_reg), .last_reg(last_reg),
    .ReadReg1(rr1), .ReadReg2(rr2), .ReadData1(rd1), .ReadData2(rd2),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data),
    .busy(busy), .done(done), .err(err), .checksum(checksum)
  );

  function automatic void preload();
    foreach (regs[i]) regs[i] = 0;
    regs[0] = 20; regs[2] = 40; regs[4] = 80; regs[8] = 160; regs[16] = 320; regs[31] = 640;
  endfunction

  // Reference: every register of the inclusive range in ascending order, stopping before stop_addr.
  function automatic void expect_range(int f, int l, int stop_addr);
    ea.delete(); ed.delete(); esum = 0;
    for (int a = f; a <= l && a != stop_addr; a++) begin
      ea.push_back(a); ed.push_back(regs[a]); esum += regs[a];
    end
  endfunction

  // mode 0: ready always high, 1: ready pattern 1,0,0 from the first beat, 2: random ready
  task automatic do_dump(input int f, input int l, input int mode, input int abort_addr, input int start_at);
    logic prev_stall = 0;
    logic [4:0] pa = 0;
    logic [31:0] pd = 0;
    oa.delete(); od.delete();
    first_cyc = -1; last_cyc = -1; done_cyc = -1; idle_cyc = -1; stall_bad = 0; timeout = 0; abort_cyc = -1;
    err_at_done = 0;
    @(negedge clk);
    first_reg = f[4:0]; last_reg = l[4:0]; start = 1; dump_ready = 0;
    @(negedge clk);
    start = 0; first_reg = 5'($urandom); last_reg = 5'($urandom);
    for (int c = 1; c <= 400; c++) begin
      abort = 0;
      start = c == start_at;
      if (c == start_at) begin first_reg = 20; last_reg = 25; end
      dump_ready = mode == 0 ? 1'b1 : mode == 1 ? ((c - 2) % 3 == 0) : 1'($urandom_range(0, 1));
      if (c == 1) begin f_rr1 = rr1; f_rr2 = rr2; end
      if (prev_stall && (!dump_valid || dump_addr !== pa || dump_data !== pd)) stall_bad++;
      if (abort_addr >= 0 && dump_valid && dump_addr == abort_addr[4:0]) begin
        abort = 1; abort_cyc = c;
      end else if (dump_valid && dump_ready) begin
        oa.push_back(dump_addr); od.push_back(dump_data);
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
      end
      if (done) begin done_cyc = c; err_at_done = err; end
      if (!busy) begin idle_cyc = c; break; end
      prev_stall = dump_valid && !dump_ready; pa = dump_addr; pd = dump_data;
      @(negedge clk);
    end
    if (idle_cyc < 0) timeout = 1;
    abort = 0; start = 0; dump_ready = 0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({busy, done, err, dump_valid} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {busy, done, err, dump_valid});
    end
    n_checks++;
    if ({rr1, rr2, dump_addr} !== 15'b0) begin
      n_fail++; $display("FAIL reset_addrs: got %0d %0d %0d want 0 0 0", rr1, rr2, dump_addr);
    end
    n_checks++;
    if ({dump_data, checksum} !== 64'b0) begin
      n_fail++; $display("FAIL reset_data: got data %0d checksum %0d want 0 0", dump_data, checksum);
    end
  endtask

  task automatic test_full_dump();
    preload();
    do_dump(0, 31, 0, -1, -1);
    expect_range(0, 31, -1);
    n_checks++;
    if (oa.size() != ea.size()) begin n_fail++; $display("FAIL full beat count: got %0d want %0d", oa.size(), ea.size()); end
    else foreach (ea[i]) begin
      n_checks++;
      if (oa[i] !== ea[i] || od[i] !== ed[i]) begin
        n_fail++; $display("FAIL full beat %0d: got (%0d,%0d) want (%0d,%0d)", i, oa[i], od[i], ea[i], ed[i]);
      end
    end
    n_checks++;
    if (checksum !== esum || esum !== 1260) begin n_fail++; $display("FAIL full checksum: got %0d want 1260", checksum); end
    n_checks++;
    if (timeout != 0) begin n_fail++; $display("FAIL full timeout: got %0d want 0", timeout); end
    n_checks++;
    if (first_cyc != 2) begin n_fail++; $display("FAIL full first beat latency: got %0d want 2", first_cyc); end
    n_checks++;
    if (last_cyc != 2 + 31 + 31 / 2) begin n_fail++; $display("FAIL full last beat cycle: got %0d want %0d", last_cyc, 2 + 31 + 31 / 2); end
    n_checks++;
    if (done_cyc != last_cyc + 1) begin n_fail++; $display("FAIL full done cycle: got %0d want %0d", done_cyc, last_cyc + 1); end
    n_checks++;
    if (idle_cyc != last_cyc + 2) begin n_fail++; $display("FAIL full busy drop: got %0d want %0d", idle_cyc, last_cyc + 2); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL full err: got %b want 0", err); end
  endtask

  task automatic test_single_and_pair();
    do_dump(31, 31, 0, -1, -1);
    expect_range(31, 31, -1);
    n_checks++;
    if (f_rr1 !== 5'd31 || f_rr2 !== 5'd31) begin n_fail++; $display("FAIL single fetch addrs: got %0d %0d want 31 31", f_rr1, f_rr2); end
    n_checks++;
    if (oa.size() != 1) begin n_fail++; $display("FAIL single beat count: got %0d want 1", oa.size()); end
    else begin
      n_checks++;
      if (oa[0] !== 31 || od[0] !== 640) begin n_fail++; $display("FAIL single beat: got (%0d,%0d) want (31,640)", oa[0], od[0]); end
    end
    n_checks++;
    if (checksum !== esum) begin n_fail++; $display("FAIL single checksum: got %0d want %0d", checksum, esum); end
    do_dump(30, 31, 0, -1, -1);
    expect_range(30, 31, -1);
    n_checks++;
    if (oa.size() != ea.size()) begin n_fail++; $display("FAIL pair beat count: got %0d want %0d", oa.size(), ea.size()); end
    else foreach (ea[i]) begin
      n_checks++;
      if (oa[i] !== ea[i] || od[i] !== ed[i]) begin
        n_fail++; $display("FAIL pair beat %0d: got (%0d,%0d) want (%0d,%0d)", i, oa[i], od[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_dump(0, 4, 1, -1, -1);
    expect_range(0, 4, -1);
    n_checks++;
    if (stall_bad != 0) begin n_fail++; $display("FAIL stall stability: got %0d unstable cycles want 0", stall_bad); end
    n_checks++;
    if (oa.size() != ea.size()) begin n_fail++; $display("FAIL stall beat count: got %0d want %0d", oa.size(), ea.size()); end
    else foreach (ea[i]) begin
      n_checks++;
      if (oa[i] !== ea[i] || od[i] !== ed[i]) begin
        n_fail++; $display("FAIL stall beat %0d: got (%0d,%0d) want (%0d,%0d)", i, oa[i], od[i], ea[i], ed[i]);
      end
    end
    n_checks++;
    if (checksum !== esum || esum !== 140) begin n_fail++; $display("FAIL stall checksum: got %0d want 140", checksum); end
  endtask

  task automatic test_bad_range();
    do_dump(8, 2, 0, -1, -1);
    n_checks++;
    if (oa.size() != 0 || first_cyc != -1) begin n_fail++; $display("FAIL badrange beats: got %0d want 0", oa.size()); end
    n_checks++;
    if (err_at_done !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL badrange err: got %b want 1", err); end
    n_checks++;
    if (done_cyc != 1 || idle_cyc != 2) begin n_fail++; $display("FAIL badrange timing: got done %0d idle %0d want 1 2", done_cyc, idle_cyc); end
    n_checks++;
    if (checksum !== 0) begin n_fail++; $display("FAIL badrange checksum: got %0d want 0", checksum); end
    do_dump(0, 0, 0, -1, -1);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL badrange err clear: got %b want 0", err); end
  endtask

  task automatic test_abort();
    do_dump(0, 31, 0, 3, 4);
    expect_range(0, 31, 3);
    n_checks++;
    if (oa.size() != ea.size()) begin n_fail++; $display("FAIL abort beat count: got %0d want %0d", oa.size(), ea.size()); end
    else foreach (ea[i]) begin
      n_checks++;
      if (oa[i] !== ea[i] || od[i] !== ed[i]) begin
        n_fail++; $display("FAIL abort beat %0d: got (%0d,%0d) want (%0d,%0d)", i, oa[i], od[i], ea[i], ed[i]);
      end
    end
    n_checks++;
    if (done_cyc != -1) begin n_fail++; $display("FAIL abort done pulse: got cycle %0d want none", done_cyc); end
    n_checks++;
    if (abort_cyc < 0 || idle_cyc != abort_cyc + 1 || dump_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort exit: got idle %0d valid %b want %0d 0", idle_cyc, dump_valid, abort_cyc + 1);
    end
    n_checks++;
    if (checksum !== esum || esum !== 60) begin n_fail++; $display("FAIL abort checksum: got %0d want 60", checksum); end
  endtask

  task automatic test_async_reset();
    int n = 0;
    @(negedge clk);
    first_reg = 0; last_reg = 31; start = 1; dump_ready = 1;
    @(negedge clk);
    start = 0;
    while (!(dump_valid && dump_addr == 5) && n < 100) begin @(negedge clk); n++; end
    n_checks++;
    if (n >= 100) begin n_fail++; $display("FAIL areset reach: got timeout want beat 5"); end
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({busy, done, err, dump_valid, rr1, rr2, dump_addr, dump_data, checksum} !== '0) begin
      n_fail++; $display("FAIL areset outputs: got busy %b valid %b addr %0d data %0d sum %0d want all 0", busy, dump_valid, dump_addr, dump_data, checksum);
    end
    @(negedge clk);
    rst_n = 1;
    dump_ready = 0;
    do_dump(0, 1, 0, -1, -1);
    n_checks++;
    if (oa.size() != 2) begin n_fail++; $display("FAIL areset beat count: got %0d want 2", oa.size()); end
    else begin
      n_checks++;
      if (oa[0] !== 0 || od[0] !== 20 || oa[1] !== 1 || od[1] !== 0) begin
        n_fail++; $display("FAIL areset beats: got (%0d,%0d)(%0d,%0d) want (0,20)(1,0)", oa[0], od[0], oa[1], od[1]);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      int f, l;
      foreach (regs[i]) regs[i] = $urandom;
      f = $urandom_range(0, 31);
      l = $urandom_range(f, 31);
      do_dump(f, l, 2, -1, -1);
      expect_range(f, l, -1);
      n_checks++;
      if (timeout != 0 || stall_bad != 0) begin n_fail++; $display("FAIL rand %0d flow: got timeout %0d stalls %0d want 0 0", t, timeout, stall_bad); end
      n_checks++;
      if (oa.size() != ea.size()) begin n_fail++; $display("FAIL rand %0d beat count: got %0d want %0d", t, oa.size(), ea.size()); end
      else foreach (ea[i]) begin
        n_checks++;
        if (oa[i] !== ea[i] || od[i] !== ed[i]) begin
          n_fail++; $display("FAIL rand %0d beat %0d: got (%0d,%0d) want (%0d,%0d)", t, i, oa[i], od[i], ea[i], ed[i]);
        end
      end
      n_checks++;
      if (checksum !== esum) begin n_fail++; $display("FAIL rand %0d checksum: got %0h want %0h", t, checksum, esum); end
    end
  endtask

  initial begin
    preload();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1;
    @(negedge clk);
    test_reset();
    test_full_dump();
    test_single_and_pair();
    test_backpressure();
    test_bad_range();
    test_abort();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
